// File: rtl/raster_pkg.sv
// Shared rasterizer definitions: screen geometry, writer FSM states and the pixel beat record.
package raster_pkg;

  localparam int unsigned H_RES  = 800;
  localparam int unsigned V_RES  = 600;
  localparam int unsigned ADDR_W = 17;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH_DRAIN,
    ST_FLUSH_PUSH,
    ST_FLUSH_WAIT
  } fb_state_e;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [7:0]  colour;
    logic        draw;
  } pixel_beat_t;

endpackage

// File: rtl/fb_addr_calc.sv
// Linear byte address y*800+x built from shifts, plus the on-screen flag.
module fb_addr_calc
  import raster_pkg::*;
#(
  parameter int unsigned H_RES = 800,
  parameter int unsigned V_RES = 600
) (
  input  logic [10:0] x,
  input  logic [10:0] y,
  output logic [18:0] addr,
  output logic        in_range
);

  logic [18:0] x_ext;
  logic [18:0] y_ext;

  assign x_ext = {8'b0, x};
  assign y_ext = {8'b0, y};

  // 800 = 512 + 256 + 32; overflow only occurs for off-screen rows
  assign addr     = (y_ext << 9) + (y_ext << 8) + (y_ext << 5) + x_ext;
  assign in_range = ({21'b0, x} < H_RES) && ({21'b0, y} < V_RES);

endmodule

// File: rtl/raster_fb_writer.sv
// Pixel stream to framebuffer writer: coalesces byte pixels into strobed 32-bit word writes.
module raster_fb_writer
  import raster_pkg::*;
#(
  parameter int unsigned H_RES  = 800,
  parameter int unsigned V_RES  = 600,
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic [10:0]       pixel_x,
  input  logic [10:0]       pixel_y,
  input  logic              draw,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  output logic              mem_valid,
  input  logic              mem_ready,
  input  logic              flush,
  output logic              flush_done,
  output logic [31:0]       pix_count,
  output logic [15:0]       drop_count
);

  fb_state_e   state, state_nxt;
  pixel_beat_t beat;
  logic [18:0] calc_addr;
  logic        calc_inr;
  logic        run_en;

  logic        s1_valid, s1_draw, s1_inr;
  logic [18:0] s1_addr;
  logic [7:0]  s1_data;

  logic              p_valid;
  logic [ADDR_W-1:0] p_addr;
  logic [31:0]       p_data;
  logic [3:0]        p_strb;

  logic        accept, out_free, s1_write, same_word, needs_out, s1_retire;
  logic        flush_push, load_out, done_set;
  logic [31:0] merge_data;
  logic [3:0]  merge_strb;

  assign beat = '{x: pixel_x, y: pixel_y, colour: in_data, draw: draw};

  fb_addr_calc #(.H_RES(H_RES), .V_RES(V_RES)) u_addr (
    .x        (beat.x),
    .y        (beat.y),
    .addr     (calc_addr),
    .in_range (calc_inr)
  );

  assign out_free  = !mem_valid || mem_ready;
  assign s1_write  = s1_valid && s1_draw && s1_inr;
  assign same_word = p_valid && (p_addr == s1_addr[ADDR_W+1:2]);
  assign needs_out = s1_write && p_valid && !same_word;
  assign s1_retire = s1_valid && (!needs_out || out_free);
  assign accept    = in_valid && in_ready;
  assign load_out  = (s1_retire && needs_out) || flush_push;

  // A different word starts from an empty lane set; the displaced word goes to the output
  always_comb begin
    merge_data = same_word ? p_data : '0;
    merge_strb = same_word ? p_strb : '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (s1_addr[1:0] == i[1:0]) begin
        merge_data[8*i +: 8] = s1_data;
        merge_strb[i]        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:         if (flush)     state_nxt = ST_FLUSH_DRAIN;
      ST_FLUSH_DRAIN: if (!s1_valid) state_nxt = ST_FLUSH_PUSH;
      ST_FLUSH_PUSH:  if (out_free)  state_nxt = ST_FLUSH_WAIT;
      ST_FLUSH_WAIT:  if (out_free)  state_nxt = ST_RUN;
      default:                       state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    in_ready   = run_en && (state == ST_RUN) && (!s1_valid || s1_retire);
    flush_push = (state == ST_FLUSH_PUSH) && out_free && p_valid;
    done_set   = (state == ST_FLUSH_WAIT) && out_free;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_en     <= 1'b0;
      flush_done <= 1'b0;
      s1_valid   <= 1'b0;
      s1_addr    <= '0;
      s1_data    <= '0;
      s1_draw    <= 1'b0;
      s1_inr     <= 1'b0;
    end else begin
      run_en     <= 1'b1;
      flush_done <= done_set;
      if (accept) begin
        s1_valid <= 1'b1;
        s1_addr  <= calc_addr;
        s1_data  <= beat.colour;
        s1_draw  <= beat.draw;
        s1_inr   <= calc_inr;
      end else if (s1_retire) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_valid <= 1'b0;
      p_addr  <= '0;
      p_data  <= '0;
      p_strb  <= '0;
    end else if (flush_push) begin
      p_valid <= 1'b0;
    end else if (s1_retire && s1_write) begin
      p_valid <= 1'b1;
      p_addr  <= s1_addr[ADDR_W+1:2];
      p_data  <= merge_data;
      p_strb  <= merge_strb;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else if (load_out) begin
      mem_valid <= 1'b1;
      mem_addr  <= p_addr;
      mem_wdata <= p_data;
      mem_wstrb <= p_strb;
    end else if (mem_ready) begin
      mem_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_count  <= '0;
      drop_count <= '0;
    end else if (s1_retire && s1_draw) begin
      if (s1_inr)                pix_count  <= pix_count + 32'd1;
      else if (drop_count != '1) drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_raster_fb_writer.sv
// Directed bench for raster_fb_writer with a write scoreboard checked by an independent monitor.
module tb_raster_fb_writer;

  logic        clk, reset;
  logic [7:0]  in_data;
  logic [10:0] pixel_x, pixel_y;
  logic        draw, in_valid, in_ready;
  logic [16:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_valid, mem_ready;
  logic        flush, flush_done;
  logic [31:0] pix_count;
  logic [15:0] drop_count;

  typedef struct {
    logic [16:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;

  wr_t         exp_q[$];
  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  int unsigned last_hs_cyc = 0;
  int unsigned done_count = 0;
  logic        hs_pending = 1'b0;
  logic        hold_prev = 1'b0;
  logic        stall_seen = 1'b0;
  logic [16:0] prev_addr;
  logic [31:0] prev_data;
  logic [3:0]  prev_strb;

  raster_fb_writer #(.H_RES(800), .V_RES(600), .ADDR_W(17)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .draw       (draw),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .flush      (flush),
    .flush_done (flush_done),
    .pix_count  (pix_count),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [16:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_t w;
    w.a = a; w.d = d; w.s = s;
    exp_q.push_back(w);
  endtask

  // Monitor: scoreboard pops, hold stability and flush_done placement
  always @(negedge clk) begin
    if (reset) begin
      hold_prev  = 1'b0;
      hs_pending = 1'b0;
    end else begin
      if (hold_prev) begin
        checks++;
        if (!(mem_valid && mem_addr == prev_addr && mem_wdata == prev_data && mem_wstrb == prev_strb)) begin
          failures++;
          $display("FAIL hold_stable actual=%0b/%0h/%0h/%0h required=1/%0h/%0h/%0h",
                   mem_valid, mem_addr, mem_wdata, mem_wstrb, prev_addr, prev_data, prev_strb);
        end
      end
      hold_prev = mem_valid && !mem_ready;
      prev_addr = mem_addr; prev_data = mem_wdata; prev_strb = mem_wstrb;
      if (flush) hs_pending = 1'b0;
      if (mem_valid && mem_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write actual=%0h/%0h/%0h required=none", mem_addr, mem_wdata, mem_wstrb);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          if (mem_addr !== w.a || mem_wdata !== w.d || mem_wstrb !== w.s) begin
            failures++;
            $display("FAIL write actual=%0h/%0h/%0h required=%0h/%0h/%0h",
                     mem_addr, mem_wdata, mem_wstrb, w.a, w.d, w.s);
          end
        end
        last_hs_cyc = cyc;
        hs_pending  = 1'b1;
      end
      if (flush_done) begin
        done_count++;
        chk("done_queue_empty", exp_q.size(), 0);
        if (hs_pending) chk("done_after_hs", cyc - last_hs_cyc, 1);
        hs_pending = 1'b0;
      end
    end
  end

  // Entered and left at posedge+1
  task automatic send_beat(input logic [10:0] x, input logic [10:0] y, input logic [7:0] c, input logic d);
    logic done;
    done = 1'b0;
    in_valid = 1'b1; pixel_x = x; pixel_y = y; in_data = c; draw = d;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else          stall_seen = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      failures++;
      $display("FAIL accept_timeout actual=0 required=1");
    end
  endtask

  task automatic do_flush();
    logic got;
    got = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      if (flush_done) got = 1'b1;
    end
    @(posedge clk); #1;
    chk("flush_done_seen", {31'b0, got}, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned dc;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; pixel_x = '0; pixel_y = '0;
    draw = 1'b0; flush = 1'b0; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 0);
    chk("rst_mem_valid", {31'b0, mem_valid}, 0);
    chk("rst_mem_addr", {15'b0, mem_addr}, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wstrb", {28'b0, mem_wstrb}, 0);
    chk("rst_flush_done", {31'b0, flush_done}, 0);
    chk("rst_pix_count", pix_count, 0);
    chk("rst_drop_count", {16'b0, drop_count}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_rst", {31'b0, in_ready}, 1);
    @(posedge clk); #1;

    // Four pixels into one word
    push_exp(17'd0, 32'h04030201, 4'b1111);
    for (int i = 0; i < 4; i++) send_beat(11'(i), 11'd0, 8'(i + 1), 1'b1);
    do_flush();
    chk("pix_count_t1", pix_count, 4);

    // Bottom-right corner, lane 3
    push_exp(17'd119999, 32'hAA000000, 4'b1000);
    send_beat(11'd799, 11'd599, 8'hAA, 1'b1);
    do_flush();
    chk("pix_count_t2", pix_count, 5);

    // Discarded and out-of-range beats
    send_beat(11'd1, 11'd1, 8'h33, 1'b0);
    send_beat(11'd2, 11'd2, 8'h44, 1'b0);
    send_beat(11'd800, 11'd0, 8'h55, 1'b1);
    idle(3);
    chk("drop_count_t3", {16'b0, drop_count}, 1);
    chk("pix_count_t3", pix_count, 5);
    do_flush();

    // 64 pixels over 16 words with a 10-cycle memory stall
    for (int k = 0; k < 16; k++)
      push_exp(17'(2000 + k), {8'(4*k + 4), 8'(4*k + 3), 8'(4*k + 2), 8'(4*k + 1)}, 4'b1111);
    stall_seen = 1'b0;
    fork
      begin
        for (int i = 0; i < 64; i++) send_beat(11'(i), 11'd10, 8'(i + 1), 1'b1);
      end
      begin
        idle(20);
        mem_ready = 1'b0;
        idle(10);
        mem_ready = 1'b1;
      end
    join
    chk("stall_seen_t4", {31'b0, stall_seen}, 1);
    do_flush();
    chk("pix_count_t4", pix_count, 69);

    // Same lane twice: later colour wins
    push_exp(17'd1001, 32'h00002200, 4'b0010);
    send_beat(11'd5, 11'd5, 8'h11, 1'b1);
    send_beat(11'd5, 11'd5, 8'h22, 1'b1);
    do_flush();
    chk("pix_count_t5", pix_count, 71);

    // Reset while a flush waits on the memory
    mem_ready = 1'b0;
    send_beat(11'd1, 11'd2, 8'h55, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    idle(5);
    @(negedge clk);
    chk("t6_pending_write", {31'b0, mem_valid}, 1);
    dc = done_count;
    @(posedge clk); #3;
    reset = 1'b1;
    @(negedge clk);
    chk("t6_mem_valid", {31'b0, mem_valid}, 0);
    chk("t6_mem_addr", {15'b0, mem_addr}, 0);
    chk("t6_mem_wdata", mem_wdata, 0);
    chk("t6_mem_wstrb", {28'b0, mem_wstrb}, 0);
    chk("t6_in_ready", {31'b0, in_ready}, 0);
    chk("t6_pix_count", pix_count, 0);
    chk("t6_flush_done", {31'b0, flush_done}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    mem_ready = 1'b1;
    idle(10);
    chk("t6_no_done", done_count, dc);
    chk("t6_drop_count", {16'b0, drop_count}, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
